// File: rtl/reg_sel_pkg.sv
// Shared definitions for the register-select / busy-scoreboard stage.
//   SEL_W_DEF : default register-field width
//   MAX_REGS  : widest one-hot vector the popcount helper handles
//   bit_pos   : register index -> one-hot bit position (MSB-first or LSB-first)
//   popcount  : number of set bits in a (zero-extended) register vector
package reg_sel_pkg;

  localparam int unsigned SEL_W_DEF = 4;
  localparam int unsigned MAX_REGS  = 256;

  function automatic int unsigned bit_pos(input int unsigned idx,
                                          input int unsigned nregs,
                                          input bit          msb_first);
    return msb_first ? (nregs - 1 - idx) : idx;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_REGS; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/reg_select_scoreboard_onehot_dec.sv
// Combinational register-field decoder.
//   field  : register index
//   en     : when low the output is all-zero
//   onehot : one-hot select, bit order set by MSB_FIRST
module onehot_dec
  import reg_sel_pkg::*;
#(
  parameter int unsigned SEL_W     = SEL_W_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic [SEL_W-1:0]      field,
  input  logic                  en,
  output logic [(2**SEL_W)-1:0] onehot
);

  logic [SEL_W-1:0] pos;

  always_comb begin
    pos    = SEL_W'(bit_pos(32'(field), 2**SEL_W, MSB_FIRST));
    onehot = '0;
    if (en) onehot[pos] = 1'b1;
  end

endmodule

// File: rtl/reg_select_scoreboard.sv
// Register-select stage with busy scoreboard.
//   clock, clear_n           : clock, async active-low reset
//   issue_valid/ready        : issue handshake (ready is combinational)
//   issue_we/dst/src_a/src_b : instruction register fields
//   wb_valid, wb_dst         : writeback from the result bus
//   out_valid, *_sel         : registered one-hot selects, one cycle after accept
//   busy, pending_cnt        : outstanding-write scoreboard and its popcount
//   wb_err                   : sticky, writeback to a non-busy register
module reg_select_scoreboard
  import reg_sel_pkg::*;
#(
  parameter int unsigned SEL_W     = SEL_W_DEF,
  parameter int unsigned NUM_REGS  = 2**SEL_W,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          ZERO_REG  = 1'b1
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic                issue_we,
  input  logic [SEL_W-1:0]    issue_dst,
  input  logic [SEL_W-1:0]    issue_src_a,
  input  logic [SEL_W-1:0]    issue_src_b,
  input  logic                wb_valid,
  input  logic [SEL_W-1:0]    wb_dst,
  output logic                out_valid,
  output logic [NUM_REGS-1:0] dst_sel,
  output logic [NUM_REGS-1:0] src_a_sel,
  output logic [NUM_REGS-1:0] src_b_sel,
  output logic [NUM_REGS-1:0] busy,
  output logic [SEL_W:0]      pending_cnt,
  output logic                wb_err
);

  localparam int unsigned CNT_W = SEL_W + 1;

  logic [NUM_REGS-1:0] dst_oh, a_oh, b_oh, wb_oh;
  logic [NUM_REGS-1:0] eff_busy, busy_nxt;
  logic [MAX_REGS-1:0] busy_ext;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                dst_en, accept, wb_bad;

  // dst_oh already excludes no-write and hard-wired R0, so it doubles as
  // the write select and the scoreboard set mask.
  assign dst_en = issue_we && !(ZERO_REG && issue_dst == '0);

  onehot_dec #(.SEL_W(SEL_W), .MSB_FIRST(MSB_FIRST)) u_dec_dst (
    .field(issue_dst), .en(dst_en), .onehot(dst_oh));
  onehot_dec #(.SEL_W(SEL_W), .MSB_FIRST(MSB_FIRST)) u_dec_a (
    .field(issue_src_a), .en(1'b1), .onehot(a_oh));
  onehot_dec #(.SEL_W(SEL_W), .MSB_FIRST(MSB_FIRST)) u_dec_b (
    .field(issue_src_b), .en(1'b1), .onehot(b_oh));
  onehot_dec #(.SEL_W(SEL_W), .MSB_FIRST(MSB_FIRST)) u_dec_wb (
    .field(wb_dst), .en(wb_valid), .onehot(wb_oh));

  // Same-cycle writeback bypasses the hazard.
  assign eff_busy    = busy & ~wb_oh;
  assign issue_ready = ~|(eff_busy & a_oh) && ~|(eff_busy & b_oh) && ~|(eff_busy & dst_oh);
  assign accept      = issue_valid && issue_ready;
  assign wb_bad      = wb_valid && ~|(busy & wb_oh);

  // Set is ORed in after the clear so a same-cycle set wins.
  always_comb begin
    busy_nxt = (busy & ~wb_oh) | (dst_oh & {NUM_REGS{accept}});
    busy_ext = '0;
    busy_ext[NUM_REGS-1:0] = busy_nxt;
    cnt_nxt  = CNT_W'(popcount(busy_ext));
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      out_valid   <= 1'b0;
      dst_sel     <= '0;
      src_a_sel   <= '0;
      src_b_sel   <= '0;
      busy        <= '0;
      pending_cnt <= '0;
      wb_err      <= 1'b0;
    end else begin
      out_valid   <= accept;
      dst_sel     <= accept ? dst_oh : '0;
      src_a_sel   <= accept ? a_oh   : '0;
      src_b_sel   <= accept ? b_oh   : '0;
      busy        <= busy_nxt;
      pending_cnt <= cnt_nxt;
      if (wb_bad) wb_err <= 1'b1;
    end
  end

endmodule
